// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, master IDs,
// fixed IFU masks and the watchdog width.
package ysyx_22041211_mem_arbiter_pkg;

  // Arbiter FSM; 2'b11 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_WAIT  = 2'b10
  } arb_state_e;

  // Master IDs double as bit positions in the request/grant vectors
  localparam logic ARB_M_IFU = 1'b0;
  localparam logic ARB_M_LSU = 1'b1;

  localparam int NUM_MASTERS = 2;

  // IFU is a read-only word fetcher
  localparam logic [7:0] IFU_RMASK = 8'b0000_1111;
  localparam logic [7:0] IFU_WMASK = 8'b0000_0000;

  // Watchdog never wraps because TIMEOUT is capped at 255
  localparam int WDOG_W = 8;

  // One-hot grant for a two-way tie: the master not served last wins
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = (last == ARB_M_IFU) ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ysyx_22041211_mem_arbiter_rr_arb2.sv
// Pure combinational 2-way round-robin picker; the pointer lives in the parent.
module ysyx_22041211_rr_arb2
  import ysyx_22041211_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // Single requester wins outright; a tie goes to the master not served last
  always_comb begin
    grant = rr_pick(req, last);
  end

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter in front of a single-port SRAM. One access in
// flight at a time; the winner's fields are latched at grant and replayed to
// the SRAM until ack, then the response is routed back to the owner. A
// watchdog turns a missing SRAM completion into an error response.
module ysyx_22041211_mem_arbiter
  import ysyx_22041211_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ifu_req,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_gnt,
  output logic                  ifu_rvalid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic                  ifu_err,

  input  logic                  lsu_req,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [7:0]            lsu_wmask,
  input  logic [7:0]            lsu_rmask,
  output logic                  lsu_gnt,
  output logic                  lsu_rvalid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_err,

  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask,
  output logic [7:0]            mem_rmask,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic                  busy
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);

  arb_state_e state_q, state_d;

  logic                  last_q;
  logic                  owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [7:0]            wmask_q;
  logic [7:0]            rmask_q;
  logic [WDOG_W-1:0]     wdog_q;

  logic [1:0] req_vec;
  logic [1:0] pick;
  logic [1:0] gnt_vec;
  logic       gnt_any;
  logic       done_ok;
  logic       done_to;
  logic       done;

  logic [NUM_MASTERS-1:0]                 rvalid_w;
  logic [NUM_MASTERS-1:0]                 err_w;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] rdata_w;

  assign req_vec = {lsu_req, ifu_req};

  ysyx_22041211_rr_arb2 u_rr_arb2 (
    .req   (req_vec),
    .last  (last_q),
    .grant (pick)
  );

  // Grant only from IDLE, and never while reset is held so gnt reads 0 in reset
  assign gnt_vec = (state_q == ARB_IDLE && rst) ? pick : 2'b00;
  assign gnt_any = |gnt_vec;

  // mem_rvalid wins over a same-cycle watchdog expiry
  assign done_ok = (state_q == ARB_WAIT) && mem_rvalid;
  assign done_to = (state_q == ARB_WAIT) && !mem_rvalid && (wdog_q == WDOG_LIMIT);
  assign done    = done_ok || done_to;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: grant -> drive SRAM until ack -> wait for completion or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (gnt_any) state_d = ARB_ISSUE;
      ARB_ISSUE: if (mem_ack) state_d = ARB_WAIT;
      ARB_WAIT:  if (done)    state_d = ARB_IDLE;
      default:                state_d = ARB_IDLE;
    endcase
  end

  // Latch winner's fields, owner and round-robin pointer on every grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= ARB_M_IFU;
      owner_q <= ARB_M_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rmask_q <= '0;
    end else if (gnt_any) begin
      last_q  <= gnt_vec[ARB_M_LSU];
      owner_q <= gnt_vec[ARB_M_LSU];
      if (gnt_vec[ARB_M_LSU]) begin
        addr_q  <= lsu_addr;
        wen_q   <= lsu_wen;
        wdata_q <= lsu_wdata;
        wmask_q <= lsu_wmask;
        rmask_q <= lsu_rmask;
      end else begin
        addr_q  <= ifu_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= IFU_WMASK;
        rmask_q <= IFU_RMASK;
      end
    end
  end

  // Watchdog: cleared on ack, counts only while waiting for completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  wdog_q <= '0;
    else if (state_q == ARB_ISSUE && mem_ack)  wdog_q <= '0;
    else if (state_q == ARB_WAIT)              wdog_q <= wdog_q + 1'b1;
  end

  // Per-master response registers; only the owner ever sees rvalid/err
  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_rsp
    logic                  mine;
    logic                  rv_q;
    logic                  er_q;
    logic [DATA_WIDTH-1:0] rd_q;

    assign mine = (owner_q == 1'(m));

    // One-cycle completion pulse; rdata holds until this master's next completion
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rv_q <= 1'b0;
        er_q <= 1'b0;
        rd_q <= '0;
      end else begin
        rv_q <= done && mine;
        er_q <= done_to && mine;
        if (done_ok && mine)      rd_q <= mem_rdata;
        else if (done_to && mine) rd_q <= '0;
      end
    end

    assign rvalid_w[m] = rv_q;
    assign err_w[m]    = er_q;
    assign rdata_w[m]  = rd_q;
  end

  assign ifu_gnt    = gnt_vec[ARB_M_IFU];
  assign lsu_gnt    = gnt_vec[ARB_M_LSU];
  assign ifu_rvalid = rvalid_w[ARB_M_IFU];
  assign lsu_rvalid = rvalid_w[ARB_M_LSU];
  assign ifu_err    = err_w[ARB_M_IFU];
  assign lsu_err    = err_w[ARB_M_LSU];
  assign ifu_rdata  = rdata_w[ARB_M_IFU];
  assign lsu_rdata  = rdata_w[ARB_M_LSU];

  assign mem_req   = (state_q == ARB_ISSUE);
  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign mem_rmask = rmask_q;

  assign busy = (state_q != ARB_IDLE);

endmodule
